cva6_bw_regulator: RTL
======================

Name: cva6_bw_regulator

Overview:
- Per-core memory-bandwidth regulator placed between each core's SPU output and the CCU slave port.
- Shares the single CCU/AXI master path fairly by gating AR/AW request handshakes against a per-core beat budget.
- Each budget is replenished every regulation period.
- The block issues no transactions itself. It only blocks or passes AR/AW handshakes and accounts burst beats; W/R/B/snoop channels bypass it.

Parameters:
- NumCores, 2, number of regulated cores (matches ariane_soc::NumCVA6).
- BudgetWidth, 16, width of budget and remaining-beat counters.
- PeriodWidth, 24, width of the period timer.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- en_i  in  1  regulation enable; 0 = transparent pass-through
- period_i  in  PeriodWidth  regulation period in cycles; 0 = transparent
- budget_i  in  NumCores*BudgetWidth  per-core beats allowed per period
- slv_ar_valid_i / slv_ar_ready_o  in/out  NumCores  per-core AR handshake, core side
- slv_ar_len_i  in  NumCores*8  AR burst length (beats-1)
- slv_aw_valid_i / slv_aw_ready_o  in/out  NumCores  per-core AW handshake, core side
- slv_aw_len_i  in  NumCores*8  AW burst length
- mst_ar_valid_o / mst_ar_ready_i  out/in  NumCores  AR handshake, CCU side
- mst_aw_valid_o / mst_aw_ready_i  out/in  NumCores  AW handshake, CCU side
- rem_o  out  NumCores*BudgetWidth  remaining beats in the current period
- throttled_o  out  NumCores  request pending and gate closed this cycle
- period_tick_o  out  1  one-cycle pulse on the period-boundary (refill) cycle

Behaviour:
- Payloads are not touched; only valid/ready are gated.
  - mst_x_valid_o = slv_x_valid_i & gate_x.
  - slv_x_ready_o = mst_x_ready_i & gate_x.
  - Zero added latency. No combinational path from any ready to any valid.
- Beat cost: beats = len+1 (9-bit). A handshake is fire = mst_valid & mst_ready.
- Gate rule per core (active = en_i & period_i!=0):
  - ar_ok = rem >= ar_beats.
  - aw_ok = rem >= aw_beats + (slv_ar_valid_i & ar_ok ? ar_beats : 0). AR has priority and the AW check is conservative.
  - gate_ar = !active | ar_ok | ar_hold; gate_aw likewise.
- Hold flags preserve AXI stability:
  - ar_hold/aw_hold set when mst_valid is asserted without fire.
  - Cleared on fire.
  - While set, the gate stays open regardless of rem.
- Remaining counter update per cycle:
  - rem_next = (tick ? budget_q : rem) - cost.
  - cost = (ar_fire?ar_beats:0) + (aw_fire?aw_beats:0).
  - Saturates at 0, never wraps. Underflow is possible only through hold flags after a budget decrease.
- Period timer:
  - Counts 0..period_i-1; tick when cnt == period_i-1 (or cnt >= period_i after period_i is reduced), then cnt <= 0.
  - budget_q is sampled from budget_i on tick, so a config change takes effect at the next boundary.
- Transparent mode (!active):
  - Gates open, timer and cnt held at 0, rem <= budget_i each cycle, throttled_o = 0.
- Refill and fire in the same cycle: rem = budget_q(new) - cost.
- Reset:
  - All registers clear: cnt=0, holds=0, budget_q=0, rem=0, init=1.
  - All mst_*_valid_o and slv_*_ready_o forced 0 while rst_i is high, including mid-burst.
  - First cycle after release: init forces a load rem <= budget_i, budget_q <= budget_i, then init <= 0. Gates are closed during that init cycle.
- Reset output values: rem_o=0, throttled_o=0, period_tick_o=0, all valids/readies 0.
- throttled_o = slv_ar_valid_i&!gate_ar | slv_aw_valid_i&!gate_aw, registered-free (combinational from state + valids).
- Cores are independent; no cross-core arbitration in this block (the CCU arbitrates).

Test Plan:
1. en=1, period=100, budget=16, core0 issues four AR len=3 bursts back-to-back with ready=1:
   - All four pass, rem 16→12→8→4→0.
   - A fifth AR is held with throttled_o=1 until the tick at cycle 99, then passes; rem=12 after it.
2. Same-cycle AR len=7 and AW len=7 with rem=10:
   - AR passes, AW gated (10 < 16).
   - After the AR fires, rem=2 and AW stays gated until refill.
3. mst_ar_valid_o asserted with ready=0 for 5 cycles while budget_i drops to 2 and a tick occurs:
   - Valid stays high (hold flag).
   - On fire rem saturates to 0, not a wrap.
4. Period 8, budget 4, AR len=0 fires exactly on the tick cycle:
   - rem = 4-1 = 3.
   - period_tick_o pulses every 8 cycles.
5. en=0 or period=0:
   - Every request passes in 0 cycles, rem_o = budget_i, throttled_o never asserts.
   - Re-enable: timer starts from 0.
6. Assert rst_i while mst_aw_valid_o is high:
   - valid drops immediately, rem=0.
   - After release, one closed init cycle, then rem=budget_i.

Source files
------------

// File: rtl/cva6_bw_regulator.sv
// -----------------------------------------------------------------------------
// cva6_bw_regulator
//
// Per-core memory-bandwidth regulator sitting between each core's SPU output
// and the CCU slave port. It never issues transactions; it only opens or closes
// the AR/AW request handshakes of each core against a per-core beat budget that
// is refilled at every regulation-period boundary. Payloads and the W/R/B and
// snoop channels do not pass through this block.
//
// Handshake semantics (all AR/AW channels, core side "slv", CCU side "mst"):
//   A transfer happens in a cycle where valid and ready are both high. Once the
//   regulator has shown mst_*_valid_o high it keeps the gate open until that
//   request is accepted, so a presented request is never withdrawn. Gating is
//   symmetric: mst_valid = slv_valid & gate, slv_ready = mst_ready & gate, and
//   gate depends only on registered state plus slv_*_valid_i, so there is no
//   combinational path from any ready input to any valid output.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   en_i                 regulation enable (0 = transparent)
//   period_i             regulation period in cycles (0 = transparent)
//   budget_i             per-core beats per period, NumCores x BudgetWidth
//   slv_ar_* / slv_aw_*  core-side AR/AW valid, ready and burst length
//   mst_ar_* / mst_aw_*  CCU-side AR/AW valid and ready
//   rem_o                per-core remaining beats in the current period
//   throttled_o          per-core: a request is pending and its gate is closed
//   period_tick_o        one-cycle pulse on the refill cycle
// -----------------------------------------------------------------------------
module cva6_bw_regulator #(
  parameter int unsigned NumCores    = 2,
  parameter int unsigned BudgetWidth = 16,
  parameter int unsigned PeriodWidth = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [PeriodWidth-1:0]          period_i,
  input  logic [NumCores*BudgetWidth-1:0] budget_i,
  input  logic [NumCores-1:0]             slv_ar_valid_i,
  output logic [NumCores-1:0]             slv_ar_ready_o,
  input  logic [NumCores*8-1:0]           slv_ar_len_i,
  input  logic [NumCores-1:0]             slv_aw_valid_i,
  output logic [NumCores-1:0]             slv_aw_ready_o,
  input  logic [NumCores*8-1:0]           slv_aw_len_i,
  output logic [NumCores-1:0]             mst_ar_valid_o,
  input  logic [NumCores-1:0]             mst_ar_ready_i,
  output logic [NumCores-1:0]             mst_aw_valid_o,
  input  logic [NumCores-1:0]             mst_aw_ready_i,
  output logic [NumCores*BudgetWidth-1:0] rem_o,
  output logic [NumCores-1:0]             throttled_o,
  output logic                            period_tick_o
);

  // Arithmetic width wide enough for a budget value or the sum of two
  // 9-bit beat counts, plus one bit so comparisons and subtraction never wrap.
  localparam int unsigned SumWidth = ((BudgetWidth > 10) ? BudgetWidth : 10) + 1;

  // ---------------------------------------------------------------------------
  // Shared period timer and init flag
  // ---------------------------------------------------------------------------
  logic                   active;
  logic                   tick;
  logic                   init_q;
  logic [PeriodWidth-1:0] cnt_q;
  logic [PeriodWidth-1:0] cnt_d;

  assign active = en_i & (period_i != '0);

  // ">=" rather than "==" so that shrinking period_i below the current count
  // produces an immediate boundary instead of waiting for the counter to wrap.
  assign tick = active & ~init_q & (cnt_q >= (period_i - PeriodWidth'(1)));

  assign period_tick_o = tick;

  always_comb begin
    cnt_d = cnt_q;
    if (init_q || !active || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PeriodWidth'(1);
    end
  end

  // init_q is high for exactly one cycle after reset release; during that
  // cycle the counters load from budget_i and every gate is held closed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      init_q <= 1'b0;
      cnt_q  <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-core regulation
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NumCores; c++) begin : g_core
    logic [BudgetWidth-1:0] budget_c;
    logic [BudgetWidth-1:0] budget_q;
    logic [BudgetWidth-1:0] budget_d;
    logic [BudgetWidth-1:0] rem_q;
    logic [BudgetWidth-1:0] rem_d;
    logic                   ar_hold_q;
    logic                   ar_hold_d;
    logic                   aw_hold_q;
    logic                   aw_hold_d;
    logic [8:0]             ar_beats;
    logic [8:0]             aw_beats;
    logic [SumWidth-1:0]    rem_ext;
    logic [SumWidth-1:0]    ar_need;
    logic [SumWidth-1:0]    aw_need;
    logic [SumWidth-1:0]    cost;
    logic [SumWidth-1:0]    base_ext;
    logic                   ar_ok;
    logic                   aw_ok;
    logic                   gate_ar;
    logic                   gate_aw;
    logic                   mst_ar_v;
    logic                   mst_aw_v;
    logic                   ar_fire;
    logic                   aw_fire;

    assign budget_c = budget_i[c*BudgetWidth +: BudgetWidth];
    assign ar_beats = {1'b0, slv_ar_len_i[c*8 +: 8]} + 9'd1;
    assign aw_beats = {1'b0, slv_aw_len_i[c*8 +: 8]} + 9'd1;
    assign rem_ext  = SumWidth'(rem_q);
    assign ar_need  = SumWidth'(ar_beats);

    // AR has priority: if an AR is pending and affordable, the AW must also
    // fit in what would be left after it. This is conservative when the AR
    // does not actually fire this cycle, which only delays the AW by a cycle.
    assign ar_ok   = rem_ext >= ar_need;
    assign aw_need = SumWidth'(aw_beats) +
                     ((slv_ar_valid_i[c] & ar_ok) ? ar_need : SumWidth'(0));
    assign aw_ok   = rem_ext >= aw_need;

    // Hold flags keep a request that is already visible on the CCU side
    // valid until it is accepted, even if the budget has since shrunk.
    assign gate_ar = ~rst_i & ~init_q & (~active | ar_ok | ar_hold_q);
    assign gate_aw = ~rst_i & ~init_q & (~active | aw_ok | aw_hold_q);

    assign mst_ar_v = slv_ar_valid_i[c] & gate_ar;
    assign mst_aw_v = slv_aw_valid_i[c] & gate_aw;
    assign ar_fire  = mst_ar_v & mst_ar_ready_i[c];
    assign aw_fire  = mst_aw_v & mst_aw_ready_i[c];

    assign mst_ar_valid_o[c] = mst_ar_v;
    assign mst_aw_valid_o[c] = mst_aw_v;
    assign slv_ar_ready_o[c] = mst_ar_ready_i[c] & gate_ar;
    assign slv_aw_ready_o[c] = mst_aw_ready_i[c] & gate_aw;

    assign throttled_o[c] = active & ~rst_i &
                            ((slv_ar_valid_i[c] & ~gate_ar) |
                             (slv_aw_valid_i[c] & ~gate_aw));

    assign rem_o[c*BudgetWidth +: BudgetWidth] = rem_q;

    always_comb begin
      budget_d  = budget_q;
      rem_d     = rem_q;
      base_ext  = rem_ext;
      ar_hold_d = ar_hold_q;
      aw_hold_d = aw_hold_q;
      cost      = (ar_fire ? ar_need : SumWidth'(0)) +
                  (aw_fire ? SumWidth'(aw_beats) : SumWidth'(0));

      if (init_q || !active) begin
        // Load / transparent: track budget_i directly, no accounting.
        budget_d = budget_c;
        rem_d    = budget_c;
      end else begin
        // On a boundary the freshly sampled budget is the refill value, and
        // any beats accepted in that same cycle are charged against it.
        if (tick) begin
          budget_d = budget_c;
          base_ext = SumWidth'(budget_c);
        end
        // Saturate at zero: a held request can cost more than what is left.
        if (cost > base_ext) begin
          rem_d = '0;
        end else begin
          rem_d = BudgetWidth'(base_ext - cost);
        end
      end

      if (ar_fire) begin
        ar_hold_d = 1'b0;
      end else if (mst_ar_v) begin
        ar_hold_d = 1'b1;
      end

      if (aw_fire) begin
        aw_hold_d = 1'b0;
      end else if (mst_aw_v) begin
        aw_hold_d = 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        budget_q  <= '0;
        rem_q     <= '0;
        ar_hold_q <= 1'b0;
        aw_hold_q <= 1'b0;
      end else begin
        budget_q  <= budget_d;
        rem_q     <= rem_d;
        ar_hold_q <= ar_hold_d;
        aw_hold_q <= aw_hold_d;
      end
    end
  end

endmodule
